// File: rtl/fb_write_arb.sv
// Round-robin arbiter sharing the framebuffer write port among NREQ drawing requesters.
// Optional vertical-blanking write window: define FB_WRITE_ARB_VBLANK_EN.
module fb_write_arb #(
  parameter int NREQ      = 3,
  parameter int ADDRW     = 15,
  parameter int DATAW     = 4,
  parameter int DEPTH     = 19200,
  parameter int MAX_BURST = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ-1:0]          req_last,
  input  logic [NREQ*ADDRW-1:0]    req_addr,
  input  logic [NREQ*DATAW-1:0]    req_colr,
  output logic [NREQ-1:0]          req_ready,
  input  logic                     vbl_start,
  input  logic                     vbl_end,
  output logic                     fb_we,
  output logic [ADDRW-1:0]         fb_addr_write,
  output logic [DATAW-1:0]         fb_colr_write,
  output logic [$clog2(NREQ)-1:0]  owner,
  output logic                     locked,
  output logic                     err_addr
);

  localparam int OW = $clog2(NREQ);
  localparam logic [ADDRW:0] DEPTH_L = (ADDRW+1)'(DEPTH);
  localparam logic [7:0]     MAXB    = 8'(MAX_BURST);

  typedef enum logic {ARB, LOCK} state_t;

  state_t           state, state_nxt;
  logic [7:0]       beat_cnt, cnt_nxt, cnt_inc;
  logic [OW-1:0]    owner_nxt, win, sel, cand;
  logic             win_found, accept, in_range;
  logic [ADDRW-1:0] sel_addr;
  logic [DATAW-1:0] sel_colr;
  logic             sel_last;
  int               idx;

  logic [ADDRW-1:0] addr_arr [NREQ];
  logic [DATAW-1:0] colr_arr [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign addr_arr[i] = req_addr[i*ADDRW +: ADDRW];
    assign colr_arr[i] = req_colr[i*DATAW +: DATAW];
  end

`ifdef FB_WRITE_ARB_VBLANK_EN
  logic window;

  // vbl_end has priority so a coincident pair leaves the window closed.
  always_ff @(posedge clk) begin
    if (rst)            window <= 1'b0;
    else if (vbl_end)   window <= 1'b0;
    else if (vbl_start) window <= 1'b1;
  end
`else
  logic window;
  logic vbl_unused;
  assign window     = 1'b1;
  assign vbl_unused = vbl_start | vbl_end;
`endif

  // Circular search starting just after the last owner.
  always_comb begin
    win       = owner;
    win_found = 1'b0;
    idx       = 0;
    cand      = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = int'(owner) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      cand = OW'(idx);
      if (!win_found && req_valid[cand]) begin
        win_found = 1'b1;
        win       = cand;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (window) begin
      if (state == LOCK)  req_ready[owner] = req_valid[owner];
      else if (win_found) req_ready[win]   = 1'b1;
    end
  end

  assign sel      = (state == LOCK) ? owner : win;
  assign accept   = |(req_valid & req_ready);
  assign sel_addr = addr_arr[sel];
  assign sel_colr = colr_arr[sel];
  assign sel_last = req_last[sel];
  assign in_range = {1'b0, sel_addr} < DEPTH_L;
  assign cnt_inc  = beat_cnt + 8'd1;
  assign locked   = (state == LOCK);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = beat_cnt;
    owner_nxt = owner;
    if (accept) begin
      case (state)
        ARB: begin
          owner_nxt = win;
          if (!sel_last && MAX_BURST > 1) begin
            state_nxt = LOCK;
            cnt_nxt   = 8'd1;
          end
        end
        LOCK: begin
          // Forced release at MAX_BURST lets the others in before the tail.
          if (sel_last || cnt_inc >= MAXB) begin
            state_nxt = ARB;
            cnt_nxt   = 8'd0;
          end else begin
            cnt_nxt = cnt_inc;
          end
        end
        default: state_nxt = ARB;
      endcase
    end
  end

  // Registered write stage: one cycle after accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ARB;
      beat_cnt      <= 8'd0;
      owner         <= OW'(NREQ-1);
      fb_we         <= 1'b0;
      fb_addr_write <= '0;
      fb_colr_write <= '0;
      err_addr      <= 1'b0;
    end else begin
      state    <= state_nxt;
      beat_cnt <= cnt_nxt;
      owner    <= owner_nxt;
      fb_we    <= accept && in_range;
      if (accept && in_range) begin
        fb_addr_write <= sel_addr;
        fb_colr_write <= sel_colr;
      end
      if (accept && !in_range) err_addr <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fb_write_arb.sv
// Scoreboard bench for fb_write_arb: expected writes are queued with the stimulus
// and compared as fb_we pulses appear.
module tb_fb_write_arb;

  localparam int NREQ  = 3;
  localparam int ADDRW = 15;
  localparam int DATAW = 4;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       req_valid, req_last, req_ready;
  logic [NREQ*ADDRW-1:0] req_addr;
  logic [NREQ*DATAW-1:0] req_colr;
  logic                  vbl_start, vbl_end;
  logic                  fb_we, locked, err_addr;
  logic [ADDRW-1:0]      fb_addr_write;
  logic [DATAW-1:0]      fb_colr_write;
  logic [1:0]            owner;

  fb_write_arb #(.NREQ(NREQ), .ADDRW(ADDRW), .DATAW(DATAW), .DEPTH(19200), .MAX_BURST(16)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_last(req_last),
    .req_addr(req_addr), .req_colr(req_colr), .req_ready(req_ready),
    .vbl_start(vbl_start), .vbl_end(vbl_end), .fb_we(fb_we),
    .fb_addr_write(fb_addr_write), .fb_colr_write(fb_colr_write),
    .owner(owner), .locked(locked), .err_addr(err_addr)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [14:0] a; logic [3:0] c; logic l; } beat_t;
  typedef struct packed { logic [14:0] a; logic [3:0] c; logic [1:0] o; logic k; } exp_t;

  beat_t bq[NREQ][$];
  exp_t  sb[$];
  int    nvec = 0, nerr = 0;
  int    cyc = 0, nwr = 0, first_wr = 0, last_wr = 0;
  logic [NREQ-1:0] acc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic push_beat(input int r, input int a, input int c, input bit l);
    beat_t b;
    b.a = 15'(a); b.c = 4'(c); b.l = l;
    bq[r].push_back(b);
  endtask

  task automatic push_exp(input int a, input int c, input int o, input bit k);
    exp_t e;
    e.a = 15'(a); e.c = 4'(c); e.o = 2'(o); e.k = k;
    sb.push_back(e);
  endtask

  task automatic monitor();
    exp_t e;
    cyc++;
    if (fb_we === 1'b1) begin
      nwr++;
      if (nwr == 1) first_wr = cyc;
      last_wr = cyc;
      if (sb.size() == 0) check("we_unexpected", 32'(fb_we), 32'd0);
      else begin
        e = sb.pop_front();
        check("wr_addr",   32'(fb_addr_write), 32'(e.a));
        check("wr_colr",   32'(fb_colr_write), 32'(e.c));
        check("wr_owner",  32'(owner),         32'(e.o));
        check("wr_locked", 32'(locked),        32'(e.k));
      end
    end
  endtask

  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      if (bq[i].size() > 0) begin
        req_valid[i]               = 1'b1;
        req_last[i]                = bq[i][0].l;
        req_addr[i*ADDRW +: ADDRW] = bq[i][0].a;
        req_colr[i*DATAW +: DATAW] = bq[i][0].c;
      end else begin
        req_valid[i] = 1'b0;
        req_last[i]  = 1'b0;
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    monitor();
    drive();
    #1;
    acc = req_valid & req_ready;
    @(posedge clk);
    if (!rst)
      for (int i = 0; i < NREQ; i++)
        if (acc[i]) void'(bq[i].pop_front());
    #1;
  endtask

  task automatic drain(input int n);
    repeat (n) step();
    check("sb_empty", 32'(sb.size()), 32'd0);
  endtask

  task automatic do_reset();
    for (int i = 0; i < NREQ; i++) bq[i].delete();
    sb.delete();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    nwr = 0;
  endtask

  initial begin
    rst = 1'b1; req_valid = '0; req_last = '0; req_addr = '0; req_colr = '0;
    vbl_start = 1'b0; vbl_end = 1'b0;

    do_reset();
    check("rst_we",     32'(fb_we),         32'd0);
    check("rst_addr",   32'(fb_addr_write), 32'd0);
    check("rst_colr",   32'(fb_colr_write), 32'd0);
    check("rst_locked", 32'(locked),        32'd0);
    check("rst_err",    32'(err_addr),      32'd0);
    check("rst_owner",  32'(owner),         32'd2);
    check("rst_ready",  32'(req_ready),     32'd0);

`ifndef FB_WRITE_ARB_VBLANK_EN
    // Two back-to-back single beats from requester 0.
    push_beat(0, 5, 7, 1); push_exp(5, 7, 0, 0);
    push_beat(0, 6, 3, 1); push_exp(6, 3, 0, 0);
    drain(4);
    check("t1_nwr",    32'(nwr),              32'd2);
    check("t1_b2b",    32'(last_wr - first_wr), 32'd1);

    // Round robin with all three requesters continuously valid.
    do_reset();
    for (int rep = 0; rep < 2; rep++)
      for (int r = 0; r < NREQ; r++) begin
        push_beat(r, 200 + rep*10 + r, r + rep*3 + 1, 1);
        push_exp(200 + rep*10 + r, r + rep*3 + 1, r, 0);
      end
    drain(9);
    check("t2_nwr", 32'(nwr),                32'd6);
    check("t2_b2b", 32'(last_wr - first_wr), 32'd5);

    // 20-beat burst from requester 1 is forced off after 16 beats.
    do_reset();
    for (int k = 1; k <= 20; k++) push_beat(1, 1000 + k, k % 16, k == 20);
    push_beat(2, 2000, 9, 1);
    for (int k = 1; k <= 16; k++) push_exp(1000 + k, k % 16, 1, k < 16);
    push_exp(2000, 9, 2, 0);
    for (int k = 17; k <= 20; k++) push_exp(1000 + k, k % 16, 1, k < 20);
    drain(30);
    check("t3_nwr",    32'(nwr),    32'd21);
    check("t3_locked", 32'(locked), 32'd0);

    // Out-of-range address: accepted silently, sticky error.
    do_reset();
    push_beat(0, 19200, 5, 1);
    drain(3);
    check("t4_nowr", 32'(nwr),      32'd0);
    check("t4_err",  32'(err_addr), 32'd1);
    check("t4_rdy",  32'(req_ready), 32'd0);
    push_beat(0, 19199, 6, 1); push_exp(19199, 6, 0, 0);
    drain(3);
    check("t4_edge_nwr", 32'(nwr),      32'd1);
    check("t4_err_hold", 32'(err_addr), 32'd1);
    do_reset();
    check("t4_err_clr",  32'(err_addr), 32'd0);

    // Reset on the third beat of a burst.
    for (int k = 1; k <= 6; k++) push_beat(0, 300 + k, k, k == 6);
    push_exp(301, 1, 0, 1);
    push_exp(302, 2, 0, 1);
    step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("t5_we",     32'(fb_we),    32'd0);
    check("t5_locked", 32'(locked),   32'd0);
    check("t5_owner",  32'(owner),    32'd2);
    check("t5_sb",     32'(sb.size()), 32'd0);
    bq[0].delete();
    push_beat(1, 400, 1, 1);
    push_beat(0, 401, 2, 1);
    push_exp(401, 2, 0, 0);
    push_exp(400, 1, 1, 0);
    drain(4);
`else
    // Writes only inside the vertical-blanking window; bursts pause across it.
    for (int k = 1; k <= 4; k++) begin
      push_beat(0, 500 + k, k + 8, k == 4);
      push_exp(500 + k, k + 8, 0, k < 4);
    end
    repeat (4) step();
    check("v_closed_nwr", 32'(nwr),       32'd0);
    check("v_closed_rdy", 32'(req_ready), 32'd0);
    vbl_start = 1'b1; step(); vbl_start = 1'b0;
    step(); step();
    vbl_end = 1'b1; step(); vbl_end = 1'b0;
    step(); step();
    check("v_pause_nwr",    32'(nwr),       32'd3);
    check("v_pause_locked", 32'(locked),    32'd1);
    check("v_pause_rdy",    32'(req_ready), 32'd0);
    vbl_start = 1'b1; step(); vbl_start = 1'b0;
    step(); step();
    check("v_resume_nwr",    32'(nwr),    32'd4);
    check("v_resume_locked", 32'(locked), 32'd0);
    check("v_sb",            32'(sb.size()), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/fb_write_arb.md
Name: fb_write_arb

Overview:
- Round-robin write arbiter for the framebuffer BRAM write port, in the system clock domain.
- Shares the single framebuffer write port between NREQ drawing requesters (fizzle fader, line/sprite drawers, clear engine).
- Each requester uses a valid/ready handshake and may lock the port for a burst of beats.
- The arbiter drives the framebuffer write-enable, address and colour from registers.

Parameters:
- NREQ, 3, number of requesters (2-8).
- ADDRW, 15, framebuffer address width (bits).
- DATAW, 4, colour index width (bits).
- DEPTH, 19200, framebuffer pixels; valid addresses are 0..DEPTH-1.
- MAX_BURST, 16, maximum beats per grant before forced release (1-255).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- req_valid  in  NREQ  per-requester beat valid.
- req_last  in  NREQ  per-requester: current beat ends the burst.
- req_addr  in  NREQ*ADDRW  packed addresses; requester i at [i*ADDRW +: ADDRW].
- req_colr  in  NREQ*DATAW  packed colours; requester i at [i*DATAW +: DATAW].
- req_ready  out  NREQ  per-requester beat accepted this cycle when valid && ready.
- vbl_start  in  1  single-cycle pulse: vertical blanking begins (used only with option).
- vbl_end  in  1  single-cycle pulse: vertical blanking ends (used only with option).
- fb_we  out  1  framebuffer write enable.
- fb_addr_write  out  ADDRW  framebuffer write address.
- fb_colr_write  out  DATAW  framebuffer write colour.
- owner  out  $clog2(NREQ)  index of the current or last granted requester.
- locked  out  1  a burst lock is held.
- err_addr  out  1  sticky: an out-of-range address was accepted; cleared only by rst.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high, rst.
- Reset values:
  - fb_we=0, fb_addr_write=0, fb_colr_write=0, locked=0, err_addr=0.
  - owner=NREQ-1, so requester 0 has first priority.
  - Internal beat counter=0; FSM in ARB.
- Accept condition: a beat is accepted when req_valid[i] && req_ready[i]. req_ready is combinational from state and req_valid. At most one bit of req_ready is high at a time.
- Write timing: an accepted beat at cycle t gives fb_we=1 at t+1, with that beat's addr and colour. No accepted beat gives fb_we=0 at t+1; addr and colour hold their previous values.
- Out-of-range beats: if addr >= DEPTH, the beat is accepted, fb_we stays 0 for it, and err_addr is set.
- FSM ARB (no lock held):
  - Winner = first i with req_valid[i], searching circularly from owner+1.
  - req_ready[winner]=1 when the window is open.
  - On accept, owner<=winner. If req_last=0 and MAX_BURST>1: go to LOCK, locked<=1, beat counter<=1. Otherwise stay in ARB.
  - Back-to-back single-beat requests sustain one write per cycle.
- FSM LOCK:
  - Only owner may be ready: req_ready[owner]=req_valid[owner] && window open. All other requesters stall.
  - Each accepted beat increments the beat counter.
  - Return to ARB (locked<=0, counter<=0) when the accepted beat has req_last=1, or when the counter reaches MAX_BURST.
  - On forced release the requester keeps its remaining beats valid and re-arbitrates; round-robin lets other requesters in first.
  - An owner with valid low holds the lock indefinitely; no timeout.
- Requester handshake rules:
  - Once req_valid is asserted it must stay high with stable addr, colour and last until accepted.
  - The arbiter never withdraws a granted ready within a cycle.
- Reset mid-burst: the lock is dropped, the in-flight fb_we is cleared next cycle, and any partially written burst is not resumed.
- Window: always open unless the optional feature is compiled in.

Optional Feature:
- Macro: FB_WRITE_ARB_VBLANK_EN.
- When defined:
  - Internal window flag: reset value 0; set by vbl_start, cleared by vbl_end. If both pulse in the same cycle, vbl_end wins (window closed).
  - While the window is closed, all req_ready=0. LOCK state and beat counter are preserved, so a burst is paused, not released.
  - Writes are therefore tear-free, occurring only during vertical blanking.
- When undefined: vbl_start and vbl_end are ignored; the window is permanently open.

Test Plan:
- Single requester 0 sends beats addr 5 colr 7 then addr 6 colr 3, last=1, back-to-back -> fb_we high 2 consecutive cycles, one cycle after each accept, with (5,7),(6,3); locked stays 0.
- All 3 requesters valid with single beats continuously -> grants cycle 0,1,2,0,1,2; one write per cycle; owner follows that sequence.
- Requester 1 sends a 20-beat burst (last on beat 20) with MAX_BURST=16 while requester 2 is valid -> 16 beats from 1, then 2 granted, then 1's remaining 4 beats; locked=1 during the 16-beat lock.
- Requester 0 addr 19200 -> accepted, no fb_we, err_addr=1 and stays 1 until rst.
- rst asserted during the 3rd beat of a burst -> next cycle fb_we=0, locked=0, owner=NREQ-1; subsequent arbitration starts at requester 0.
- With FB_WRITE_ARB_VBLANK_EN: beats pending, no vbl_start -> no writes. vbl_start -> writes begin. vbl_end mid-burst -> ready drops, locked stays 1. Next vbl_start -> burst resumes at the next beat.
